// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, Zicsr op encodings
// and the bit positions of the implemented mstatus/mie/mip fields.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [2:0] {
    CsrOpRw  = 3'b001,
    CsrOpRs  = 3'b010,
    CsrOpRc  = 3'b011,
    CsrOpRwi = 3'b101,
    CsrOpRsi = 3'b110,
    CsrOpRci = 3'b111
  } csr_op_e;

  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;
  // mie uses the same positions for MTIE/MEIE as mip does for MTIP/MEIP.
  localparam int unsigned MTIP_BIT = 7;
  localparam int unsigned MEIP_BIT = 11;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half CSR write; a write to either half takes
// precedence over the increment for the whole counter in that cycle.
module csr_counter64 #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            wr_lo,
  input  logic            wr_hi,
  input  logic [XLEN-1:0] wdata,
  output logic [63:0]     count
);

  logic [63:0] count_q, count_d;

  if (XLEN >= 64) begin : g_wide
    always_comb begin
      count_d = inc ? count_q + 64'd1 : count_q;
      if (wr_lo || wr_hi) begin
        count_d = wdata[63:0];
      end
    end
  end else begin : g_narrow
    always_comb begin
      count_d = inc ? count_q + 64'd1 : count_q;
      if (wr_lo) begin
        count_d = {count_q[63:32], wdata[31:0]};
      end else if (wr_hi) begin
        count_d = {wdata[31:0], count_q[31:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR unit: Zicsr ops, trap entry/mret, interrupt latching and trap vector.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters.
module csr_file
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter int unsigned     MEPC_ALIGN  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic [2:0]      csr_op,
  input  logic            csr_en,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            rs1_zero,
  input  logic [XLEN-1:0] pc,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret,
  input  logic            instret,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] trap_vec,
  output logic            irq_pending,
  output logic            illegal
);

  localparam logic [XLEN-1:0] EpcMask = {XLEN{1'b1}} << MEPC_ALIGN;

  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic            mtie_q, mtie_d, meie_q, meie_d;
  logic            mtip_q, mtip_d, meip_q, meip_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;

  logic [XLEN-1:0] rval, wval, tvec_base;
  logic            addr_ok, read_only, is_write, wr_en;

`ifdef CSR_COUNTERS_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  // Read mux; also classifies the address as implemented / read-only.
  always_comb begin
    rval      = '0;
    addr_ok   = 1'b1;
    read_only = 1'b0;
    case (csr_addr)
      CSR_MSTATUS: begin
        rval[MIE_BIT]  = mie_q;
        rval[MPIE_BIT] = mpie_q;
      end
      CSR_MIE: begin
        rval[MTIP_BIT] = mtie_q;
        rval[MEIP_BIT] = meie_q;
      end
      CSR_MTVEC:    rval = mtvec_q;
      CSR_MSCRATCH: rval = mscratch_q;
      CSR_MEPC:     rval = mepc_q;
      CSR_MCAUSE:   rval = mcause_q;
      CSR_MIP: begin
        rval[MTIP_BIT] = mtip_q;
        rval[MEIP_BIT] = meip_q;
        read_only      = 1'b1;
      end
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   rval = cycle_cnt[XLEN-1:0];
      CSR_MINSTRET: rval = instret_cnt[XLEN-1:0];
      CSR_MCYCLEH: begin
        if (XLEN == 32) rval = XLEN'(cycle_cnt[63:32]);
        else            addr_ok = 1'b0;
      end
      CSR_MINSTRETH: begin
        if (XLEN == 32) rval = XLEN'(instret_cnt[63:32]);
        else            addr_ok = 1'b0;
      end
`endif
      default: addr_ok = 1'b0;
    endcase
  end

  // Set/clear ops with a zero source are pure reads.
  always_comb begin
    is_write = csr_en && (csr_op[1:0] != 2'b00) && (!csr_op[1] || !rs1_zero);
    case (csr_op_e'(csr_op))
      CsrOpRs, CsrOpRsi: wval = rval | csr_wdata;
      CsrOpRc, CsrOpRci: wval = rval & ~csr_wdata;
      default:           wval = csr_wdata;
    endcase
  end

  assign wr_en       = is_write && addr_ok && !read_only && !trap && !mret;
  assign rdata       = csr_en ? rval : '0;
  assign illegal     = csr_en && (!addr_ok || (read_only && is_write));
  assign epc         = mepc_q;
  assign irq_pending = mie_q && ((mtie_q && mtip_q) || (meie_q && meip_q));

  always_comb begin
    tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    trap_vec  = tvec_base;
    if (mtvec_q[1:0] == 2'b01 && trap_cause[XLEN-1]) begin
      trap_vec = tvec_base + {trap_cause[XLEN-3:0], 2'b00};
    end
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtie_d     = mtie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtip_d     = irq_timer;
    meip_d     = irq_ext;
    if (trap) begin
      mepc_d   = pc & EpcMask;
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_d  = wval[MIE_BIT];
          mpie_d = wval[MPIE_BIT];
        end
        CSR_MIE: begin
          mtie_d = wval[MTIP_BIT];
          meie_d = wval[MEIP_BIT];
        end
        CSR_MTVEC:    mtvec_d    = wval;
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = wval & EpcMask;
        CSR_MCAUSE:   mcause_d   = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtip_q     <= 1'b0;
      meip_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtie_q     <= mtie_d;
      meie_q     <= meie_d;
      mtip_q     <= mtip_d;
      meip_q     <= meip_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter64 #(
    .XLEN(XLEN)
  ) u_mcycle (
    .clk  (clk),
    .rst  (rst),
    .inc  (1'b1),
    .wr_lo(wr_en && csr_addr == CSR_MCYCLE),
    .wr_hi(wr_en && csr_addr == CSR_MCYCLEH),
    .wdata(wval),
    .count(cycle_cnt)
  );

  csr_counter64 #(
    .XLEN(XLEN)
  ) u_minstret (
    .clk  (clk),
    .rst  (rst),
    .inc  (instret),
    .wr_lo(wr_en && csr_addr == CSR_MINSTRET),
    .wr_hi(wr_en && csr_addr == CSR_MINSTRETH),
    .wdata(wval),
    .count(instret_cnt)
  );
`else
  logic unused_instret;
  assign unused_instret = instret;
`endif

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; counter checks follow CSR_COUNTERS_EN.
module tb_csr_file;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [11:0]     csr_addr;
  logic [2:0]      csr_op;
  logic            csr_en;
  logic [XLEN-1:0] csr_wdata;
  logic            rs1_zero;
  logic [XLEN-1:0] pc;
  logic            trap;
  logic [XLEN-1:0] trap_cause;
  logic            mret;
  logic            instret;
  logic            irq_timer;
  logic            irq_ext;
  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] trap_vec;
  logic            irq_pending;
  logic            illegal;

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] rd;
  logic            ill;

  csr_file #(
    .XLEN       (XLEN),
    .MTVEC_RESET(32'h0000_0100),
    .MEPC_ALIGN (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .csr_addr   (csr_addr),
    .csr_op     (csr_op),
    .csr_en     (csr_en),
    .csr_wdata  (csr_wdata),
    .rs1_zero   (rs1_zero),
    .pc         (pc),
    .trap       (trap),
    .trap_cause (trap_cause),
    .mret       (mret),
    .instret    (instret),
    .irq_timer  (irq_timer),
    .irq_ext    (irq_ext),
    .rdata      (rdata),
    .epc        (epc),
    .trap_vec   (trap_vec),
    .irq_pending(irq_pending),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pure read via csrrs rd, csr, x0; no clock edge is consumed.
  task automatic csr_read(input logic [11:0] addr, output logic [XLEN-1:0] data,
                          output logic ill_o);
    csr_addr  = addr;
    csr_op    = 3'b010;
    csr_wdata = '0;
    rs1_zero  = 1'b1;
    csr_en    = 1'b1;
    #1;
    data  = rdata;
    ill_o = illegal;
    csr_en = 1'b0;
    #1;
  endtask

  task automatic csr_write(input logic [2:0] op, input logic [11:0] addr,
                           input logic [XLEN-1:0] data, input logic zero);
    csr_addr  = addr;
    csr_op    = op;
    csr_wdata = data;
    rs1_zero  = zero;
    csr_en    = 1'b1;
    tick();
    csr_en    = 1'b0;
    rs1_zero  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; csr_addr = '0; csr_op = '0; csr_en = 1'b0; csr_wdata = '0;
    rs1_zero = 1'b0; pc = '0; trap = 1'b0; trap_cause = '0; mret = 1'b0;
    instret = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
    tick();
    tick();
    check("rst_rdata", rdata, 0);
    check("rst_epc", epc, 0);
    check("rst_irq", irq_pending, 0);
    check("rst_illegal", illegal, 0);
    rst = 1'b1;
    tick();

    csr_read(12'h305, rd, ill);  check("mtvec_reset", rd, 32'h100);
    csr_read(12'h300, rd, ill);  check("mstatus_reset", rd, 0);

    csr_write(3'b001, 12'h340, 32'hDEADBEEF, 1'b0);
    csr_read(12'h340, rd, ill);  check("scratch_rw", rd, 32'hDEADBEEF);
    csr_write(3'b010, 12'h340, 32'h1, 1'b0);
    csr_read(12'h340, rd, ill);  check("scratch_rs", rd, 32'hDEADBEEF);
    csr_write(3'b011, 12'h340, 32'hF0, 1'b0);
    csr_read(12'h340, rd, ill);  check("scratch_rc", rd, 32'hDEADBE0F);
    csr_write(3'b010, 12'h340, 32'hFFFF, 1'b1);
    csr_read(12'h340, rd, ill);  check("scratch_rs_zero", rd, 32'hDEADBE0F);
    csr_write(3'b111, 12'h340, 32'h0000000F, 1'b0);
    csr_read(12'h340, rd, ill);  check("scratch_rci", rd, 32'hDEADBE00);

    csr_write(3'b001, 12'h300, 32'hFFFFFFFF, 1'b0);
    csr_read(12'h300, rd, ill);  check("mstatus_mask", rd, 32'h88);
    csr_write(3'b001, 12'h300, 32'h8, 1'b0);
    csr_read(12'h300, rd, ill);  check("mstatus_mie", rd, 32'h8);
    csr_write(3'b001, 12'h304, 32'hFFFFFFFF, 1'b0);
    csr_read(12'h304, rd, ill);  check("mie_mask", rd, 32'h880);
    csr_write(3'b001, 12'h304, 32'h80, 1'b0);

    irq_timer = 1'b1;
    #1;
    check("irq_latency", irq_pending, 0);
    tick();
    check("irq_pending", irq_pending, 1);
    csr_read(12'h344, rd, ill);  check("mip_read", rd, 32'h80);

    pc = 32'h246; trap_cause = 32'h8000_0007; trap = 1'b1;
    tick();
    trap = 1'b0;
    check("trap_epc", epc, 32'h244);
    check("trap_irq_off", irq_pending, 0);
    csr_read(12'h300, rd, ill);  check("trap_mstatus", rd, 32'h80);
    csr_read(12'h342, rd, ill);  check("trap_mcause", rd, 32'h8000_0007);

    mret = 1'b1;
    tick();
    mret = 1'b0;
    csr_read(12'h300, rd, ill);  check("mret_mstatus", rd, 32'h88);
    check("mret_irq", irq_pending, 1);
    irq_timer = 1'b0;
    irq_ext   = 1'b1;
    tick();
    check("irq_drop", irq_pending, 0);
    irq_ext = 1'b0;

    csr_addr = 12'h344; csr_op = 3'b001; csr_wdata = 32'hFFF; rs1_zero = 1'b0; csr_en = 1'b1;
    #1;
    check("mip_write_illegal", illegal, 1);
    tick();
    csr_en = 1'b0;
    csr_read(12'h344, rd, ill);  check("mip_unchanged", rd, 0);
    check("mip_read_legal", ill, 0);
    csr_read(12'h7C0, rd, ill);
    check("unknown_illegal", ill, 1);
    check("unknown_rdata", rd, 0);

    csr_write(3'b001, 12'h341, 32'h57, 1'b0);
    check("mepc_align", epc, 32'h54);

    csr_write(3'b001, 12'h305, 32'h201, 1'b0);
    trap_cause = 32'h8000_000B; #1;
    check("tvec_vectored", trap_vec, 32'h22C);
    trap_cause = 32'h2; #1;
    check("tvec_exception", trap_vec, 32'h200);
    csr_write(3'b001, 12'h305, 32'h202, 1'b0);
    trap_cause = 32'h8000_000B; #1;
    check("tvec_mode2", trap_vec, 32'h200);

    // trap, mret and a CSR write in one cycle: only the trap lands.
    pc = 32'h300; trap_cause = 32'h3; trap = 1'b1; mret = 1'b1;
    csr_write(3'b001, 12'h341, 32'h55, 1'b0);
    trap = 1'b0; mret = 1'b0;
    check("prio_epc", epc, 32'h300);
    csr_read(12'h300, rd, ill);  check("prio_mstatus", rd, 32'h80);

`ifdef CSR_COUNTERS_EN
    csr_write(3'b001, 12'hB00, 32'hFFFFFFFF, 1'b0);
    csr_read(12'hB80, rd, ill);  check("mcycleh_before", rd, 0);
    tick();
    csr_read(12'hB80, rd, ill);  check("mcycleh_carry", rd, 1);
    csr_read(12'hB00, rd, ill);  check("mcycle_wrap", rd, 0);
    instret = 1'b1;
    csr_write(3'b001, 12'hB02, 32'h5, 1'b0);
    tick();
    tick();
    instret = 1'b0;
    csr_read(12'hB02, rd, ill);  check("minstret", rd, 7);
    csr_read(12'hB82, rd, ill);  check("minstreth", rd, 0);
`else
    csr_read(12'hB00, rd, ill);
    check("mcycle_absent_ill", ill, 1);
    check("mcycle_absent_rd", rd, 0);
    csr_read(12'hB82, rd, ill);
    check("minstreth_absent_ill", ill, 1);
`endif

    // Reset wins over a simultaneous trap.
    pc = 32'h400; trap = 1'b1; rst = 1'b0;
    tick();
    trap = 1'b0; rst = 1'b1;
    check("rst_mid_epc", epc, 0);
    csr_read(12'h305, rd, ill);  check("rst_mid_mtvec", rd, 32'h100);
    csr_read(12'h340, rd, ill);  check("rst_mid_scratch", rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
